rtype_instr_encoder: RTL and testbench

Encoder counterpart to the R-type control decoder: converts ALU-operation requests (4-bit ALU control code plus register indices) into 32-bit RV32I R-type instruction words. Requests enter via a valid/ready handshake, are encoded, tagged with a sequential word address and buffered in a small FIFO. Words stream out on a second valid/ready interface to an instruction-memory loader or directly into the decoder for self-check.

---
 rtl/rtype_instr_encoder.sv | 109 ++++++++++
 tb/tb_rtype_instr_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rtype_instr_encoder.sv
// Encodes ALU-operation requests into RV32I R-type words tagged with a
// sequential byte address, buffered in a DEPTH-entry FIFO.
module rtype_instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_alu_op,
    input  logic [4:0]               req_rd,
    input  logic [4:0]               req_rs1,
    input  logic [4:0]               req_rs2,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [31:0]              instr_addr,
    output logic                     illegal_pulse,
    output logic                     illegal_seen,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW + 1)'(1);
    localparam logic [6:0]  OPCODE_OP  = 7'b0110011;

    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   addr_cnt;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   word;

    always_comb begin
        funct7 = '0;
        funct3 = '0;
        legal  = 1'b1;
        case (req_alu_op)
            4'b0000: funct3 = 3'b000;
            4'b0001: begin funct7 = 7'b0100000; funct3 = 3'b000; end
            4'b0010: funct3 = 3'b001;
            4'b0011: funct3 = 3'b010;
            4'b0100: funct3 = 3'b011;
            4'b0101: funct3 = 3'b100;
            4'b0110: funct3 = 3'b101;
            4'b0111: begin funct7 = 7'b0100000; funct3 = 3'b101; end
            4'b1000: funct3 = 3'b110;
            4'b1001: funct3 = 3'b111;
            default: legal = 1'b0;
        endcase
    end

    assign word        = {funct7, req_rs2, req_rs1, funct3, req_rd, OPCODE_OP};
    assign req_ready   = (fifo_count != FULL_COUNT);
    assign instr_valid = (fifo_count != '0);
    assign accept      = req_valid && req_ready;
    assign push        = accept && legal;
    // Pop is gated by instr_valid, so a push into an empty FIFO never pops.
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = mem_data[rd_ptr];
    assign instr_addr  = mem_addr[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_addr[i] <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= word;
            mem_addr[wr_ptr] <= addr_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            addr_cnt      <= BASE_ADDR;
            illegal_pulse <= 1'b0;
            illegal_seen  <= 1'b0;
        end else begin
            illegal_pulse <= accept && !legal;
            if (accept && !legal) begin
                illegal_seen <= 1'b1;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                addr_cnt <= addr_cnt + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE;
                2'b01:   fifo_count <= fifo_count - ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Directed self-checking bench for rtype_instr_encoder (DEPTH=4).
module tb_rtype_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_alu_op;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_addr;
    logic        illegal_pulse;
    logic        illegal_seen;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    rtype_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_alu_op(req_alu_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_addr(instr_addr),
        .illegal_pulse(illegal_pulse), .illegal_seen(illegal_seen),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
        req_valid  = v;
        req_alu_op = op;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
    endtask

    logic [31:0] exp_tbl [10] = '{32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033,
                                  32'h00003033, 32'h00004033, 32'h00005033, 32'h40005033,
                                  32'h00006033, 32'h00007033};

    initial begin
        rst_n = 1'b0;
        instr_ready = 1'b0;
        set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h0);
        chk("rst_illegal_pulse", 32'(illegal_pulse), 32'd0);
        chk("rst_illegal_seen", 32'(illegal_seen), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        #9 rst_n = 1'b1;

        // ADD x3, x1, x2 with consumer ready
        instr_ready = 1'b1;
        set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2);
        cyc();
        chk("add_valid", 32'(instr_valid), 32'd1);
        chk("add_data", instr_data, 32'h002081B3);
        chk("add_addr", instr_addr, BASE);

        // All ten legal codes back-to-back; head is always the word just pushed
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, 4'(i), 5'd0, 5'd0, 5'd0);
            cyc();
            chk($sformatf("code%0d_data", i), instr_data, exp_tbl[i]);
            chk($sformatf("code%0d_addr", i), instr_addr, BASE + 32'd4 + 32'(4 * i));
            chk($sformatf("code%0d_count", i), 32'(fifo_count), 32'd1);
        end
        req_valid = 1'b0;
        cyc();
        chk("drain_valid", 32'(instr_valid), 32'd0);

        // Fill to DEPTH with consumer stalled, fifth request held
        instr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_req(1'b1, 4'd0, 5'(i), 5'd0, 5'd0);
            chk($sformatf("fill%0d_ready", i), 32'(req_ready), 32'd1);
            cyc();
        end
        set_req(1'b1, 4'd0, 5'd5, 5'd0, 5'd0);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("held_count", 32'(fifo_count), 32'd4);
        chk("held_head", instr_data, 32'h000000B3);
        chk("held_addr", instr_addr, BASE + 32'd44);
        instr_ready = 1'b1;
        cyc();
        chk("pop1_count", 32'(fifo_count), 32'd3);
        chk("pop1_ready", 32'(req_ready), 32'd1);
        chk("pop1_head", instr_data, 32'h00000133);
        cyc();
        req_valid = 1'b0;
        chk("pop2_count", 32'(fifo_count), 32'd3);
        chk("pop2_head", instr_data, 32'h000001B3);
        cyc();
        chk("pop3_head", instr_data, 32'h00000233);
        chk("pop3_count", 32'(fifo_count), 32'd2);
        cyc();
        chk("pop4_head", instr_data, 32'h000002B3);
        chk("pop4_addr", instr_addr, BASE + 32'd60);
        cyc();
        chk("pop5_count", 32'(fifo_count), 32'd0);

        // Illegal code: accepted, dropped, flagged
        instr_ready = 1'b0;
        set_req(1'b1, 4'b1100, 5'd1, 5'd1, 5'd1);
        chk("ill_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("ill_pulse", 32'(illegal_pulse), 32'd1);
        chk("ill_seen", 32'(illegal_seen), 32'd1);
        chk("ill_count", 32'(fifo_count), 32'd0);
        cyc();
        chk("ill_pulse_off", 32'(illegal_pulse), 32'd0);
        chk("ill_seen_sticky", 32'(illegal_seen), 32'd1);
        set_req(1'b1, 4'd0, 5'd7, 5'd0, 5'd0);
        cyc();
        chk("post_ill_data", instr_data, 32'h000003B3);
        chk("post_ill_addr", instr_addr, BASE + 32'd64);

        // Push+pop at count=2 across pointer wrap
        set_req(1'b1, 4'd0, 5'd8, 5'd0, 5'd0);
        cyc();
        chk("pp_pre_count", 32'(fifo_count), 32'd2);
        instr_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            set_req(1'b1, 4'd0, 5'(9 + j), 5'd0, 5'd0);
            cyc();
            chk($sformatf("pp%0d_count", j), 32'(fifo_count), 32'd2);
            chk($sformatf("pp%0d_data", j), instr_data, 32'h33 | (32'(8 + j) << 7));
            chk($sformatf("pp%0d_addr", j), instr_addr, BASE + 32'd68 + 32'(4 * j));
        end
        instr_ready = 1'b0;
        set_req(1'b1, 4'd0, 5'd19, 5'd0, 5'd0);
        cyc();
        req_valid = 1'b0;
        chk("pre_rst_count", 32'(fifo_count), 32'd3);

        // Asynchronous reset mid-stream
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(fifo_count), 32'd0);
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
        chk("mrst_data", instr_data, 32'h0);
        chk("mrst_addr", instr_addr, 32'h0);
        chk("mrst_seen", 32'(illegal_seen), 32'd0);
        #3 rst_n = 1'b1;
        set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2);
        cyc();
        req_valid = 1'b0;
        chk("after_rst_data", instr_data, 32'h002081B3);
        chk("after_rst_addr", instr_addr, BASE);
        chk("after_rst_count", 32'(fifo_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
